// File: rtl/scemi_out_port_arbiter_if.sv
// rtl/scemi_out_port_arbiter_if.sv - channel-side and out-port-side signals of scemi_out_port_arbiter
// Message width grows by 32 bits when SCEMI_ARB_CYCLE_STAMP_EN is defined.
interface scemi_out_port_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 2
);
`ifdef SCEMI_ARB_CYCLE_STAMP_EN
    localparam int MsgWidth = IdWidth + DataWidth + 32;
`else
    localparam int MsgWidth = IdWidth + DataWidth;
`endif

    logic                        CclockEnabled;
    logic                        ReadyForCclock;
    logic [NumReq-1:0]           ReqValid;
    logic [NumReq*DataWidth-1:0] ReqData;
    logic [NumReq-1:0]           ReqReady;
    logic                        TransmitReady;
    logic                        ReceiveReady;
    logic [MsgWidth-1:0]         Message;
    logic                        ProtoErr;

    modport master (
        input  CclockEnabled, ReqValid, ReqData, ReceiveReady,
        output ReadyForCclock, ReqReady, TransmitReady, Message, ProtoErr
    );

    modport slave (
        output CclockEnabled, ReqValid, ReqData, ReceiveReady,
        input  ReadyForCclock, ReqReady, TransmitReady, Message, ProtoErr
    );
endinterface

// File: rtl/scemi_out_port_arbiter.sv
// rtl/scemi_out_port_arbiter.sv - round-robin share of one SCE-MI out port among NumReq channels
// Optional per-message capture stamp: SCEMI_ARB_CYCLE_STAMP_EN.
module scemi_out_port_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 2
) (
    input  logic                     Uclock,
    input  logic                     Ureset,
    scemi_out_port_arbiter_if.master bus
);
`ifdef SCEMI_ARB_CYCLE_STAMP_EN
    localparam int MsgW = IdWidth + DataWidth + 32;
`else
    localparam int MsgW = IdWidth + DataWidth;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [NumReq-1:0]    full;
    logic [DataWidth-1:0] buf_data [NumReq];
    logic [IdWidth-1:0]   rr_ptr;
    logic [IdWidth-1:0]   grant;
    logic                 trdy_q;
    logic [MsgW-1:0]      msg_q;
    logic                 protoerr_q;

    logic [NumReq-1:0]    cap_mask;
    logic [NumReq-1:0]    viol_mask;
    logic [NumReq-1:0]    clr_mask;
    logic                 accept;

    logic [NumReq-1:0]    search_mask;
    logic [NumReq-1:0]    rot_mask;
    logic [IdWidth-1:0]   search_start;
    logic [IdWidth-1:0]   pick_idx;
    logic                 pick_found;
    int                   pick_sum;
    logic [MsgW-1:0]      pick_msg;

    function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] p);
        if (int'(p) == NumReq - 1)
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign accept = (state == SEND) && bus.ReceiveReady;

    // A full buffer at the sampling edge is a violation even if it is being cleared that same edge.
    always_comb begin
        cap_mask  = '0;
        viol_mask = '0;
        clr_mask  = '0;
        for (int i = 0; i < NumReq; i++) begin
            cap_mask[i]  = bus.CclockEnabled && bus.ReqValid[i] && !full[i];
            viol_mask[i] = bus.CclockEnabled && bus.ReqValid[i] && full[i];
            clr_mask[i]  = accept && (grant == IdWidth'(i));
        end
    end

    // Rotate so bit 0 is the search start; the lowest set bit is the next grant.
    always_comb begin
        if (state == SEND) begin
            search_mask  = full & ~clr_mask;
            search_start = wrap_inc(grant);
        end else begin
            search_mask  = full;
            search_start = rr_ptr;
        end
        rot_mask   = NumReq'({search_mask, search_mask} >> search_start);
        pick_found = 1'b0;
        pick_sum   = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (rot_mask[k]) begin
                pick_found = 1'b1;
                pick_sum   = int'(search_start) + k;
            end
        end
        if (pick_sum >= NumReq)
            pick_sum = pick_sum - NumReq;
        pick_idx = IdWidth'(pick_sum);
    end

    always_ff @(posedge Uclock) begin
        if (Ureset)
            full <= '0;
        else
            full <= (full & ~clr_mask) | cap_mask;
    end

    always_ff @(posedge Uclock) begin
        for (int i = 0; i < NumReq; i++) begin
            if (cap_mask[i])
                buf_data[i] <= bus.ReqData[i*DataWidth +: DataWidth];
        end
    end

`ifdef SCEMI_ARB_CYCLE_STAMP_EN
    logic [31:0] cyc_cnt;
    logic [31:0] buf_stamp [NumReq];

    // The stamp is the count before this edge's increment.
    always_ff @(posedge Uclock) begin
        if (Ureset)
            cyc_cnt <= '0;
        else if (bus.CclockEnabled)
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    always_ff @(posedge Uclock) begin
        for (int i = 0; i < NumReq; i++) begin
            if (cap_mask[i])
                buf_stamp[i] <= cyc_cnt;
        end
    end

    assign pick_msg = {buf_stamp[pick_idx], pick_idx, buf_data[pick_idx]};
`else
    assign pick_msg = {pick_idx, buf_data[pick_idx]};
`endif

    always_ff @(posedge Uclock) begin
        if (Ureset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            trdy_q     <= 1'b0;
            msg_q      <= '0;
            protoerr_q <= 1'b0;
        end else begin
            if (|viol_mask)
                protoerr_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant  <= pick_idx;
                        msg_q  <= pick_msg;
                        trdy_q <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (bus.ReceiveReady) begin
                        rr_ptr <= wrap_inc(grant);
                        if (pick_found) begin
                            grant <= pick_idx;
                            msg_q <= pick_msg;
                        end else begin
                            trdy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ReqReady       = ~full;
    assign bus.ReadyForCclock = ~|full;
    assign bus.TransmitReady  = trdy_q;
    assign bus.Message        = msg_q;
    assign bus.ProtoErr       = protoerr_q;
endmodule

// File: tb/tb_scemi_out_port_arbiter.sv
// tb/tb_scemi_out_port_arbiter.sv - directed self-checking bench for scemi_out_port_arbiter
module tb_scemi_out_port_arbiter;
    localparam int NumReq    = 4;
    localparam int DataWidth = 32;
    localparam int IdWidth   = 2;
    localparam int IdLo      = DataWidth;

    logic Uclock = 1'b0;
    logic Ureset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    scemi_out_port_arbiter_if #(.NumReq(NumReq), .DataWidth(DataWidth), .IdWidth(IdWidth)) bus ();

    scemi_out_port_arbiter #(.NumReq(NumReq), .DataWidth(DataWidth), .IdWidth(IdWidth)) dut (
        .Uclock (Uclock),
        .Ureset (Ureset),
        .bus    (bus.master)
    );

    always #5 Uclock = ~Uclock;

    task automatic step();
        @(posedge Uclock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [DataWidth-1:0] d);
        bus.ReqData[ch*DataWidth +: DataWidth] = d;
    endtask

    task automatic check_msg(input string tag, input logic [IdWidth-1:0] id, input logic [DataWidth-1:0] d);
        check({tag, "_tr"}, bus.TransmitReady, 1'b1);
        check({tag, "_id"}, bus.Message[IdLo +: IdWidth], id);
        check({tag, "_data"}, bus.Message[DataWidth-1:0], d);
    endtask

    task automatic do_reset();
        Ureset = 1'b1;
        step();
        step();
        Ureset = 1'b0;
    endtask

    logic [DataWidth-1:0] held_msg;
    logic [IdWidth-1:0]   rr2_ids [4];

    initial begin
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        bus.ReqData       = '0;
        bus.ReceiveReady  = 1'b1;
        rr2_ids[0] = 2'd2; rr2_ids[1] = 2'd3; rr2_ids[2] = 2'd0; rr2_ids[3] = 2'd1;

        // reset and idle
        do_reset();
        check("rst_rfc", bus.ReadyForCclock, 1'b1);
        check("rst_reqready", bus.ReqReady, 4'b1111);
        check("rst_tr", bus.TransmitReady, 1'b0);
        check("rst_perr", bus.ProtoErr, 1'b0);
        check("rst_msg", bus.Message, '0);
        step();
        check("idle_rfc", bus.ReadyForCclock, 1'b1);
        check("idle_tr", bus.TransmitReady, 1'b0);

        // single channel 2
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b0100;
        set_data(2, 32'hDEADBEEF);
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        check("single_rfc_low", bus.ReadyForCclock, 1'b0);
        check("single_reqready", bus.ReqReady, 4'b1011);
        check("single_tr_early", bus.TransmitReady, 1'b0);
        step();
        check_msg("single", 2'd2, 32'hDEADBEEF);
        step();
        check("single_tr_done", bus.TransmitReady, 1'b0);
        check("single_rfc_back", bus.ReadyForCclock, 1'b1);

        // round robin from rr_ptr=0
        do_reset();
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 32'h1000_0000 + 32'(i));
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_msg($sformatf("rr1_%0d", k), 2'(k), 32'h1000_0000 + 32'(k));
        end
        step();
        check("rr1_tr_done", bus.TransmitReady, 1'b0);
        check("rr1_rfc", bus.ReadyForCclock, 1'b1);

        // backpressure on channel 1 (leaves rr_ptr=2)
        bus.ReceiveReady  = 1'b0;
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b0010;
        set_data(1, 32'h1111_2222);
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        step();
        for (int k = 0; k < 10; k++) begin
            check_msg($sformatf("bp_%0d", k), 2'd1, 32'h1111_2222);
            check($sformatf("bp_rfc_%0d", k), bus.ReadyForCclock, 1'b0);
            step();
        end
        bus.ReceiveReady = 1'b1;
        step();
        check("bp_tr_done", bus.TransmitReady, 1'b0);
        check("bp_reqready", bus.ReqReady, 4'b1111);

        // second round from rr_ptr=2
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 32'h2000_0000 + 32'(i));
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_msg($sformatf("rr2_%0d", k), rr2_ids[k], 32'h2000_0000 + 32'(rr2_ids[k]));
        end
        step();
        check("rr2_tr_done", bus.TransmitReady, 1'b0);

        // protocol violation on full buffer 0
        bus.ReceiveReady  = 1'b0;
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b0001;
        set_data(0, 32'hCAFEF00D);
        step();
        check("pv_perr_before", bus.ProtoErr, 1'b0);
        set_data(0, 32'hBADBAD00);
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        check("pv_perr_set", bus.ProtoErr, 1'b1);
        check_msg("pv_orig", 2'd0, 32'hCAFEF00D);
        bus.ReceiveReady = 1'b1;
        step();
        check("pv_tr_done", bus.TransmitReady, 1'b0);
        check("pv_reqready", bus.ReqReady, 4'b1111);
        step();
        step();
        check("pv_perr_sticky", bus.ProtoErr, 1'b1);

        // capture on ch3 while ch0 is accepted in the same edge
        bus.ReceiveReady  = 1'b0;
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b0001;
        set_data(0, 32'h0000_00A0);
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        step();
        check_msg("cc_first", 2'd0, 32'h0000_00A0);
        bus.ReceiveReady  = 1'b1;
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b1000;
        set_data(3, 32'h0000_00A3);
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        check("cc_reqready", bus.ReqReady, 4'b0111);
        check("cc_tr_gap", bus.TransmitReady, 1'b0);
        step();
        check_msg("cc_second", 2'd3, 32'h0000_00A3);
        step();
        check("cc_rfc", bus.ReadyForCclock, 1'b1);

        // reset mid-SEND with three buffers full
        bus.ReceiveReady  = 1'b0;
        bus.CclockEnabled = 1'b1;
        bus.ReqValid      = 4'b1011;
        for (int i = 0; i < 4; i++) set_data(i, 32'h3000_0000 + 32'(i));
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        step();
        check("mr_tr_pre", bus.TransmitReady, 1'b1);
        Ureset = 1'b1;
        step();
        Ureset = 1'b0;
        check("mr_tr", bus.TransmitReady, 1'b0);
        check("mr_reqready", bus.ReqReady, 4'b1111);
        check("mr_perr", bus.ProtoErr, 1'b0);
        check("mr_rfc", bus.ReadyForCclock, 1'b1);
        bus.ReceiveReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mr_quiet_%0d", k), bus.TransmitReady, 1'b0);
        end

`ifdef SCEMI_ARB_CYCLE_STAMP_EN
        // capture on the 5th CclockEnabled cycle after reset
        do_reset();
        bus.CclockEnabled = 1'b1;
        for (int k = 0; k < 4; k++) step();
        bus.ReqValid = 4'b0010;
        set_data(1, 32'h5555_AAAA);
        step();
        bus.CclockEnabled = 1'b0;
        bus.ReqValid      = '0;
        step();
        check_msg("stamp_msg", 2'd1, 32'h5555_AAAA);
        check("stamp_val", bus.Message[IdLo+IdWidth +: 32], 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
